// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and helpers for the data-memory responder
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(mem_size_e sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - little-endian lane select/extend for loads and lane merge for stores
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [63:0] ld_dword,
    input  logic [2:0]  offset,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [63:0] ld_data,
    input  logic [63:0] st_old,
    input  logic [63:0] st_wdata,
    output logic [63:0] st_merged
);

    logic [63:0] ld_shifted;
    logic [63:0] st_shifted;
    logic [7:0]  byte_mask;
    logic [7:0]  lane_mask;

    // Load path: bring the addressed lane down to bit 0, then sign- or zero-extend it
    always_comb begin
        ld_shifted = ld_dword >> {offset, 3'b000};
        ld_data    = ld_shifted;
        case (size)
            SZ_B: ld_data = is_unsigned ? {56'd0, ld_shifted[7:0]}
                                        : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_H: ld_data = is_unsigned ? {48'd0, ld_shifted[15:0]}
                                        : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W: ld_data = is_unsigned ? {32'd0, ld_shifted[31:0]}
                                        : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    // Store path: move the right-aligned store data up to its lane and replace only those bytes
    always_comb begin
        byte_mask  = 8'((9'd1 << size_bytes(size)) - 9'd1);
        lane_mask  = byte_mask << offset;
        st_shifted = st_wdata << {offset, 3'b000};
        st_merged  = st_old;
        for (int b = 0; b < 8; b++) begin
            if (lane_mask[b]) begin
                st_merged[8*b +: 8] = st_shifted[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - stallable single-outstanding data-memory responder
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_e state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    mem_size_e   size_q, size_d;
    logic        uns_q, uns_d;
    logic [63:0] wdata_q, wdata_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic [63:0]      rel_dw;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       nbytes;
    logic             misalign;
    logic             out_of_range;
    logic             acc_err;
    logic             access;
    logic             mem_we;
    logic [63:0]      rd_dword;
    logic [63:0]      ld_data;
    logic [63:0]      st_merged;

    // Address decode of the captured request: doubleword index and error classification
    always_comb begin
        rel_dw       = (addr_q - BASE_ADDR) >> 3;
        word_idx     = rel_dw[IDX_W-1:0];
        nbytes       = size_bytes(size_q);
        misalign     = |({1'b0, addr_q[2:0]} & (nbytes - 4'd1));
        out_of_range = (rel_dw >= 64'(DEPTH_WORDS));
        acc_err      = misalign | out_of_range;
        access       = (state_q == WAIT) && (cnt_q == 4'd0);
        mem_we       = access && we_q && !acc_err;
        rd_dword     = mem[word_idx];
    end

    dmem_lane_align u_align (
        .ld_dword    (rd_dword),
        .offset      (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ld_data     (ld_data),
        .st_old      (rd_dword),
        .st_wdata    (wdata_q),
        .st_merged   (st_merged)
    );

    // Next-state logic: accept in IDLE, count wait states, access, then hold the response
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = mem_size_e'(req_size);
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_rdata_d = (acc_err || we_q) ? 64'd0 : ld_data;
                    rsp_err_d   = acc_err;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
        // req_ready is a pure register so the core sees no input-to-ready path
        req_ready_d = (state_d == IDLE);
    end

    // FSM, response and captured-request registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 64'd0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            wdata_q     <= 64'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
        end
    end

    // Storage array: written only at the access edge of a legal store, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= st_merged;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb/tb_riscv_dmem_responder.sv - self-checking bench for riscv_dmem_responder
module tb_riscv_dmem_responder;

    localparam int          DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h0;
    localparam int          NDUT  = 4;

    function automatic int wait_of(input int g);
        case (g)
            0: return 1;
            1: return 3;
            2: return 0;
            default: return 15;
        endcase
    endfunction

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]        req_valid;
    logic [NDUT-1:0]        req_ready;
    logic [NDUT-1:0]        req_we;
    logic [NDUT-1:0][63:0]  req_addr;
    logic [NDUT-1:0][1:0]   req_size;
    logic [NDUT-1:0]        req_unsigned;
    logic [NDUT-1:0][63:0]  req_wdata;
    logic [NDUT-1:0]        rsp_valid;
    logic [NDUT-1:0]        rsp_ready;
    logic [NDUT-1:0][63:0]  rsp_rdata;
    logic [NDUT-1:0]        rsp_err;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        riscv_dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .WAIT_CYCLES (wait_of(g)),
            .BASE_ADDR   (BASE)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_addr     (req_addr[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g])
        );
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] mdl [NDUT][2048];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory with the error rules applied directly
    task automatic model(input int i, input logic we, input logic [63:0] addr, input logic [1:0] sz,
                         input logic uns, input logic [63:0] wd,
                         output logic [63:0] rd, output logic er);
        int nb;
        int base;
        logic [63:0] v;
        nb = 1 << sz;
        v = 64'd0;
        er = ((addr % nb) != 0) || ((addr - BASE) >= 64'(8 * DEPTH));
        rd = 64'd0;
        if (!er) begin
            base = int'(addr[10:0]);
            for (int b = 0; b < nb; b++) begin
                if (we) mdl[i][base + b] = wd[8*b +: 8];
                else    v[8*b +: 8] = mdl[i][base + b];
            end
            if (!we) begin
                if (!uns && nb < 8 && v[8*nb-1]) begin
                    for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
                end
                rd = v;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            chk({tag, "_req_ready"}, 64'(req_ready[g]), 64'd0);
            chk({tag, "_rsp_valid"}, 64'(rsp_valid[g]), 64'd0);
            chk({tag, "_rsp_rdata"}, rsp_rdata[g], 64'd0);
            chk({tag, "_rsp_err"}, 64'(rsp_err[g]), 64'd0);
        end
    endtask

    // One full transaction; entered and left at 1 time unit after a rising edge
    task automatic xact(input int i, input logic we, input logic [63:0] addr, input logic [1:0] sz,
                        input logic uns, input logic [63:0] wd, input int hold,
                        output logic [63:0] rd, output logic er);
        logic [63:0] erd;
        logic        eer;
        logic [63:0] held;
        int n;
        model(i, we, addr, sz, uns, wd, erd, eer);
        req_we[i] = we;
        req_addr[i] = addr;
        req_size[i] = sz;
        req_unsigned[i] = uns;
        req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        rsp_ready[i] = (hold == 0);
        n = 0;
        while (!req_ready[i] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", 64'(req_ready[i]), 64'd1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_addr[i] = {$urandom, $urandom};
        req_wdata[i] = {$urandom, $urandom};
        req_we[i] = 1'($urandom);
        req_size[i] = 2'($urandom);
        n = 0;
        while (!rsp_valid[i] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(wait_of(i) + 1));
        chk("rsp_rdata", rsp_rdata[i], erd);
        chk("rsp_err", 64'(rsp_err[i]), 64'(eer));
        rd = rsp_rdata[i];
        er = rsp_err[i];
        held = rd;
        if (hold > 0) begin
            req_valid[i] = 1'b1;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                chk("bp_rsp_valid", 64'(rsp_valid[i]), 64'd1);
                chk("bp_rsp_rdata", rsp_rdata[i], held);
                chk("bp_req_ready", 64'(req_ready[i]), 64'd0);
            end
            rsp_ready[i] = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        chk("post_rsp_valid", 64'(rsp_valid[i]), 64'd0);
        chk("post_req_ready", 64'(req_ready[i]), 64'd1);
    endtask

    task automatic rand_op(input int i);
        logic [63:0] addr;
        logic [63:0] rd;
        logic        er;
        case ($urandom_range(0, 9))
            0: addr = 64'h800 + 64'($urandom_range(0, 64));
            1: addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            default: addr = 64'($urandom_range(0, 127));
        endcase
        xact(i, 1'($urandom), addr, 2'($urandom_range(0, 3)), 1'($urandom),
             {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 2 : 0, rd, er);
    endtask

    task automatic prefill(input int i);
        logic [63:0] rd;
        logic        er;
        for (int w = 0; w < 16; w++) begin
            xact(i, 1'b1, 64'(8 * w), 2'd3, 1'b0, {$urandom, $urandom}, 0, rd, er);
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [63:0] v28;
        logic [63:0] erd;
        logic        eer;
        int n;

        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_size = '0;
        req_unsigned = '0;
        req_wdata = '0;
        rsp_ready = '1;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < NDUT; g++) chk("ready_after_reset", 64'(req_ready[g]), 64'd1);

        // Directed sequence on the WAIT_CYCLES=1 instance
        xact(0, 1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, 0, rd, er);
        chk("sd_rdata_zero", rd, 64'd0);
        xact(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0, rd, er);
        chk("ld_10", rd, 64'h1122334455667788);
        chk("ld_10_err", 64'(er), 64'd0);
        xact(0, 1'b0, 64'h17, 2'd0, 1'b0, 64'd0, 0, rd, er);
        chk("lb_17", rd, 64'h0000000000000011);
        xact(0, 1'b1, 64'h11, 2'd0, 1'b0, 64'h00000000000000F0, 0, rd, er);
        xact(0, 1'b0, 64'h11, 2'd0, 1'b0, 64'd0, 0, rd, er);
        chk("lb_11", rd, 64'hFFFFFFFFFFFFFFF0);
        xact(0, 1'b0, 64'h11, 2'd0, 1'b1, 64'd0, 0, rd, er);
        chk("lbu_11", rd, 64'h00000000000000F0);
        xact(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 0, rd, er);
        chk("ld_10_merged", rd, 64'h112233445566F088);
        xact(0, 1'b0, 64'h12, 2'd2, 1'b0, 64'd0, 0, rd, er);
        chk("lw_mis_err", 64'(er), 64'd1);
        chk("lw_mis_rdata", rd, 64'd0);
        xact(0, 1'b1, 64'h0, 2'd3, 1'b0, 64'h0123456789ABCDEF, 0, rd, er);
        xact(0, 1'b1, BASE + 64'(8 * DEPTH), 2'd3, 1'b0, 64'hDEADBEEFCAFEF00D, 0, rd, er);
        chk("sd_oor_err", 64'(er), 64'd1);
        xact(0, 1'b0, 64'h0, 2'd3, 1'b0, 64'd0, 0, rd, er);
        chk("ld_0_unchanged", rd, 64'h0123456789ABCDEF);
        xact(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 5, rd, er);
        chk("bp_ld_10", rd, 64'h112233445566F088);
        xact(0, 1'b0, 64'h16, 2'd1, 1'b1, 64'd0, 0, rd, er);
        chk("lhu_16", rd, 64'h0000000000001122);

        // Reset during WAIT drops the store (WAIT_CYCLES=3 instance)
        xact(1, 1'b1, 64'h20, 2'd3, 1'b0, 64'h5A5A5A5A12345678, 0, rd, er);
        req_we[1] = 1'b1;
        req_addr[1] = 64'h20;
        req_size[1] = 2'd3;
        req_unsigned[1] = 1'b0;
        req_wdata[1] = 64'hAA;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("wait_req_ready", 64'(req_ready[1]), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_wait");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_wait_reset", 64'(req_ready[1]), 64'd1);
        xact(1, 1'b0, 64'h20, 2'd3, 1'b0, 64'd0, 0, rd, er);
        chk("ld_20_prior", rd, 64'h5A5A5A5A12345678);

        // Reset during RESP drops the response but keeps the completed store
        v28 = 64'h0F1E2D3C4B5A6978;
        req_we[1] = 1'b1;
        req_addr[1] = 64'h28;
        req_size[1] = 2'd3;
        req_unsigned[1] = 1'b0;
        req_wdata[1] = v28;
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        n = 0;
        while (!rsp_valid[1] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("resp_reached", 64'(rsp_valid[1]), 64'd1);
        model(1, 1'b1, 64'h28, 2'd3, 1'b0, v28, erd, eer);
        reset = 1'b0;
        #1;
        chk("reset_mid_resp_valid", 64'(rsp_valid[1]), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        xact(1, 1'b0, 64'h28, 2'd3, 1'b0, 64'd0, 0, rd, er);
        chk("ld_28_kept", rd, v28);

        // Randomized traffic on WAIT_CYCLES 0, 1 and 15 instances
        prefill(2);
        for (int k = 0; k < 40; k++) rand_op(2);
        prefill(0);
        for (int k = 0; k < 30; k++) rand_op(0);
        prefill(3);
        for (int k = 0; k < 15; k++) rand_op(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
